// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with frame markers
//
// Purpose:
//    Accepts a WIDTH-bit word over a valid/ready load handshake and shifts
//    it out one bit per clock. Each word forms one frame. frame_start marks
//    the first bit and frame_last marks the final bit. A word offered during
//    the frame_last cycle is accepted there, so the bit stream has no gap.
//
// Ports:
//    clk           in   1      rising-edge clock
//    reset         in   1      synchronous, active-high reset
//    datain        in   WIDTH  parallel word, sampled only on handshake
//    load_valid    in   1      source has a word on datain
//    load_ready    out  1      serializer can accept a word this cycle
//    serial_out    out  1      current serial bit, 0 when idle
//    serial_valid  out  1      serial_out carries a data bit this cycle
//    frame_start   out  1      high with the first bit of each word
//    frame_last    out  1      high with the last bit of each word
//    busy          out  1      same as serial_valid

module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] datain,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             frame_last,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;

   logic in_shift;
   logic at_last;
   logic handshake;
   logic head_bit;

   // Output decode uses only registered state. The one input that reaches
   // an output is reset, which holds load_ready low while it is asserted.
   always_comb begin
      in_shift     = (state_q == ST_SHIFT);
      at_last      = in_shift && (cnt_q == CNT_LAST);
      head_bit     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      serial_valid = in_shift;
      busy         = in_shift;
      serial_out   = in_shift && head_bit;
      frame_start  = in_shift && (cnt_q == '0);
      frame_last   = at_last;
      load_ready   = !reset && (!in_shift || at_last);
      handshake    = load_valid && load_ready;
   end

   // A load takes priority over the end-of-frame return to IDLE. This lets
   // a word accepted on the last bit continue directly into a new frame.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (handshake) begin
         state_d = ST_SHIFT;
         shreg_d = datain;
         cnt_d   = '0;
      end else if (in_shift) begin
         shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
         if (at_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
